uart_rx_frame_check: RTL and testbench
======================================

# uart_rx_frame_check

Parametrised receive-side frame checker for the UART receiver, replacing the single-width, even/odd-only parity checker. It captures a received character, its parity bit and its stop bit on a one-cycle `load` strobe, then reports parity and framing errors one cycle later with a valid pulse. It also keeps sticky status flags and saturating per-error-type counters for the host status registers. It sits between the RX deserialiser FSM and the RX FIFO / register file.

## Interface

**Parameters**
- `DATA_WIDTH`, default 8: maximum character width; legal range 5..9.
- `CNT_WIDTH`, default 8: width of each error counter.

**Ports**
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: block enable; while low, `load` is ignored.
- `load`, input, 1: one-cycle strobe from the deserialiser; samples `data_in`, `parity_bit` and `stop_bit`.
- `data_in`, input, `DATA_WIDTH`: received character, LSB = first bit received.
- `parity_bit`, input, 1: received parity bit.
- `stop_bit`, input, 1: sampled first stop bit; must be 1 for a good frame.
- `data_len`, input, 4: active character length, 5..`DATA_WIDTH`.
- `parity_en`, input, 1: parity checking enabled.
- `parity_type`, input, 2: 00 even, 01 odd, 10 mark, 11 space.
- `clear_stats`, input, 1: synchronous clear of the counters and sticky flags.
- `result_valid`, output, 1: one-cycle pulse; result outputs are updated.
- `data_out`, output, `DATA_WIDTH`: captured character; bits at and above `data_len` are forced to 0.
- `parity_error`, output, 1: parity error for the last character.
- `frame_error`, output, 1: framing error for the last character.
- `parity_sticky`, output, 1: a parity error has occurred since the last clear.
- `frame_sticky`, output, 1: a framing error has occurred since the last clear.
- `parity_err_cnt`, output, `CNT_WIDTH`: saturating parity-error count.
- `frame_err_cnt`, output, `CNT_WIDTH`: saturating framing-error count.

## Operation

- **Accepted load:** a load is accepted when `load && enable` at a rising edge.
- **Character masking:** `data_len` is sampled with the data. A value below 5 or above `DATA_WIDTH` is treated as `DATA_WIDTH`. The masked character `m` is `data_in` with bits [`DATA_WIDTH`-1:`data_len`] set to 0.
- **Expected parity:**
  - even: `^m`
  - odd: `~^m`
  - mark: 1
  - space: 0
- **Parity error:** `parity_error = parity_en && (parity_bit != expected)`. When `parity_en` = 0, `parity_bit` is ignored and `parity_error` = 0.
- **Framing error:** `frame_error = (stop_bit == 0)`, independent of parity settings.
- **Result update on an accepted load:**
  - `data_out` ← `m`
  - `parity_error` and `frame_error` are computed as above.
  - `result_valid` ← 1
- **Hold behaviour:** result outputs hold until the next accepted load. `result_valid` is 1 only for the cycle following an accepted load.
- **Counters:** on an accepted load, each counter increments by 1 if its error is set. A counter at all-ones stays at all-ones; it never wraps.
- **Sticky flags:** each sticky flag sets when its error is set and stays set until `clear_stats` or `reset`.
- **clear_stats:** zeroes both counters and both sticky flags. It has priority over a simultaneous accepted load: that load's errors are not counted and not made sticky. Its result outputs and `result_valid` still update normally.
- **Configuration changes:** `parity_type`, `parity_en` and `data_len` may change at any time. They only affect loads sampled after the change.
- **Frame rate:** back-to-back loads on consecutive cycles are legal. Each one produces its own `result_valid` pulse and its own count update.

## Timing

- **Reset:** while `reset` = 1, every output is 0: `result_valid`, `data_out`, both error outputs, both sticky flags and both counters. `reset` overrides `load` and `clear_stats` in the same cycle.
- **Latency:** 1 cycle. If a load is accepted at edge N, the result outputs, counters and sticky flags are all valid after edge N, and `result_valid` is high from edge N to edge N+1.
- **Output registers:** all outputs are registered; there is no combinational path from inputs to outputs.
- **Reset mid-operation:** a load in the same cycle as `reset` is lost; no `result_valid` pulse follows.

## Test plan

- **Reset:** hold `reset` for 2 cycles while pulsing `load` → all outputs read 0 and no `result_valid`. Release, then load 8'hA5 with `parity_bit`=0, even parity, `stop_bit`=1 → next cycle `result_valid`=1, `data_out`=A5, both errors 0.
- **Parity modes:** at `data_len`=8, load 8'h01 under each type.
  - even with `parity_bit`=0 → `parity_error`=1
  - odd with `parity_bit`=0 → `parity_error`=0
  - mark with `parity_bit`=0 → `parity_error`=1
  - space with `parity_bit`=0 → `parity_error`=0
  - repeat any case with `parity_en`=0 → `parity_error`=0
- **Width masking:** `data_len`=5, `data_in`=8'hE3, even parity, `parity_bit`=1 → `data_out`=8'h03 and `parity_error`=1, because the parity of the masked value is 0. With `data_len`=3 the same load is treated as width 8 → `data_out`=E3.
- **Framing and stickiness:** load with `stop_bit`=0 → `frame_error`=1, `frame_sticky`=1, `frame_err_cnt`=1. Then load a good frame → `frame_error`=0, but the sticky flag and count stay at 1.
- **Saturation:** with `CNT_WIDTH`=4, apply 20 back-to-back parity-error loads → 20 `result_valid` pulses and `parity_err_cnt` stops at 15. Then assert `clear_stats` together with one more error load → counter 0, sticky 0, `result_valid`=1, `parity_error`=1.
- **Enable gating:** assert `load` with `enable`=0 and `stop_bit`=0 → no `result_valid`, and all outputs unchanged.

Source files
------------

// File: rtl/uart_rx_frame_check.sv
// Receive-side frame checker: masks the captured character to the active length, checks
// parity and stop bit, and keeps sticky flags plus saturating error counters.
module uart_rx_frame_check #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  parity_bit,
  input  logic                  stop_bit,
  input  logic [3:0]            data_len,
  input  logic                  parity_en,
  input  logic [1:0]            parity_type,
  input  logic                  clear_stats,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  parity_sticky,
  output logic                  frame_sticky,
  output logic [CNT_WIDTH-1:0]  parity_err_cnt,
  output logic [CNT_WIDTH-1:0]  frame_err_cnt
);

  localparam logic [3:0]           MinLen = 4'd5;
  localparam logic [3:0]           MaxLen = 4'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic                  accept;
  logic [3:0]            eff_len;
  logic [DATA_WIDTH-1:0] masked;
  logic                  exp_par;
  logic                  par_err;
  logic                  frm_err;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_err_q, par_err_d;
  logic                  frm_err_q, frm_err_d;
  logic                  par_sticky_q, par_sticky_d;
  logic                  frm_sticky_q, frm_sticky_d;
  logic [CNT_WIDTH-1:0]  par_cnt_q, par_cnt_d;
  logic [CNT_WIDTH-1:0]  frm_cnt_q, frm_cnt_d;

  assign accept = load & enable;

  // Character check: out-of-range lengths fall back to the full width.
  always_comb begin
    eff_len = data_len;
    if (data_len < MinLen || data_len > MaxLen) begin
      eff_len = MaxLen;
    end
    masked = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (4'(i) < eff_len) begin
        masked[i] = data_in[i];
      end
    end
    case (parity_type)
      2'b00:   exp_par = ^masked;
      2'b01:   exp_par = ~^masked;
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
    par_err = parity_en & (parity_bit != exp_par);
    frm_err = ~stop_bit;
  end

  always_comb begin
    valid_d      = accept;
    data_d       = data_q;
    par_err_d    = par_err_q;
    frm_err_d    = frm_err_q;
    par_sticky_d = par_sticky_q;
    frm_sticky_d = frm_sticky_q;
    par_cnt_d    = par_cnt_q;
    frm_cnt_d    = frm_cnt_q;
    if (accept) begin
      data_d    = masked;
      par_err_d = par_err;
      frm_err_d = frm_err;
    end
    // Clear wins over a simultaneous load's statistics, not over its result.
    if (clear_stats) begin
      par_sticky_d = 1'b0;
      frm_sticky_d = 1'b0;
      par_cnt_d    = '0;
      frm_cnt_d    = '0;
    end else if (accept) begin
      if (par_err) begin
        par_sticky_d = 1'b1;
        if (par_cnt_q != '1) par_cnt_d = par_cnt_q + CntOne;
      end
      if (frm_err) begin
        frm_sticky_d = 1'b1;
        if (frm_cnt_q != '1) frm_cnt_d = frm_cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      par_sticky_q <= 1'b0;
      frm_sticky_q <= 1'b0;
      par_cnt_q    <= '0;
      frm_cnt_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      par_err_q    <= par_err_d;
      frm_err_q    <= frm_err_d;
      par_sticky_q <= par_sticky_d;
      frm_sticky_q <= frm_sticky_d;
      par_cnt_q    <= par_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
    end
  end

  assign result_valid   = valid_q;
  assign data_out       = data_q;
  assign parity_error   = par_err_q;
  assign frame_error    = frm_err_q;
  assign parity_sticky  = par_sticky_q;
  assign frame_sticky   = frm_sticky_q;
  assign parity_err_cnt = par_cnt_q;
  assign frame_err_cnt  = frm_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: arithmetic reference model checked every cycle, plus
// directed loads with hand-computed expectations.
module tb_uart_rx_frame_check;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          load = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          parity_bit = 1'b0;
  logic          stop_bit = 1'b1;
  logic [3:0]    data_len = 4'd8;
  logic          parity_en = 1'b1;
  logic [1:0]    parity_type = 2'b00;
  logic          clear_stats = 1'b0;
  logic          result_valid;
  logic [DW-1:0] data_out;
  logic          parity_error, frame_error, parity_sticky, frame_sticky;
  logic [CW-1:0] parity_err_cnt, frame_err_cnt;

  uart_rx_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .data_in(data_in),
    .parity_bit(parity_bit), .stop_bit(stop_bit), .data_len(data_len),
    .parity_en(parity_en), .parity_type(parity_type), .clear_stats(clear_stats),
    .result_valid(result_valid), .data_out(data_out), .parity_error(parity_error),
    .frame_error(frame_error), .parity_sticky(parity_sticky), .frame_sticky(frame_sticky),
    .parity_err_cnt(parity_err_cnt), .frame_err_cnt(frame_err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  bit started = 0;

  // Reference model state
  int m_valid = 0, m_data = 0, m_perr = 0, m_ferr = 0;
  int m_psticky = 0, m_fsticky = 0, m_pcnt = 0, m_fcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int len, m, ones, expar;
    started = 1;
    if (reset) begin
      m_valid = 0; m_data = 0; m_perr = 0; m_ferr = 0;
      m_psticky = 0; m_fsticky = 0; m_pcnt = 0; m_fcnt = 0;
    end else begin
      m_valid = 0;
      if (load && enable) begin
        len = (data_len < 5 || data_len > DW) ? DW : int'(data_len);
        m = int'(data_in) % (1 << len);
        ones = $countones(m);
        case (parity_type)
          2'd0: expar = ones % 2;
          2'd1: expar = 1 - ones % 2;
          2'd2: expar = 1;
          default: expar = 0;
        endcase
        m_valid = 1;
        m_data = m;
        m_perr = (parity_en && int'(parity_bit) != expar) ? 1 : 0;
        m_ferr = stop_bit ? 0 : 1;
        if (!clear_stats) begin
          if (m_perr == 1) begin m_psticky = 1; if (m_pcnt < CntMax) m_pcnt++; end
          if (m_ferr == 1) begin m_fsticky = 1; if (m_fcnt < CntMax) m_fcnt++; end
        end
      end
      if (clear_stats) begin
        m_psticky = 0; m_fsticky = 0; m_pcnt = 0; m_fcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_valid", result_valid, m_valid);
      chk("m_data", data_out, m_data);
      chk("m_perr", parity_error, m_perr);
      chk("m_ferr", frame_error, m_ferr);
      chk("m_psticky", parity_sticky, m_psticky);
      chk("m_fsticky", frame_sticky, m_fsticky);
      chk("m_pcnt", parity_err_cnt, m_pcnt);
      chk("m_fcnt", frame_err_cnt, m_fcnt);
      if (result_valid === 1'b1) pulses++;
    end
  end

  // One accepted-load cycle; inputs settle well before the sampling edge.
  task automatic do_load(input logic [DW-1:0] d, input logic pb, input logic sb,
                         input logic [1:0] pt, input logic pe, input logic [3:0] len);
    data_in = d; parity_bit = pb; stop_bit = sb; parity_type = pt;
    parity_en = pe; data_len = len; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic do_clear();
    clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    // Reset with load pulsing
    reset = 1'b1; load = 1'b1; data_in = 8'hFF; stop_bit = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_valid", result_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_fcnt", frame_err_cnt, 0);
    load = 1'b0; stop_bit = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_valid", result_valid, 0);

    do_load(8'hA5, 1'b0, 1'b1, 2'd0, 1'b1, 4'd8);
    chk("a5_valid", result_valid, 1);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_perr", parity_error, 0);
    chk("a5_ferr", frame_error, 0);
    @(negedge clk); #1;
    chk("a5_valid_drop", result_valid, 0);
    chk("a5_hold", data_out, 8'hA5);

    // Parity modes on 8'h01
    do_load(8'h01, 1'b0, 1'b1, 2'd0, 1'b1, 4'd8); chk("even", parity_error, 1);
    do_load(8'h01, 1'b0, 1'b1, 2'd1, 1'b1, 4'd8); chk("odd", parity_error, 0);
    do_load(8'h01, 1'b0, 1'b1, 2'd2, 1'b1, 4'd8); chk("mark", parity_error, 1);
    do_load(8'h01, 1'b0, 1'b1, 2'd3, 1'b1, 4'd8); chk("space", parity_error, 0);
    do_load(8'h01, 1'b0, 1'b1, 2'd0, 1'b0, 4'd8); chk("par_dis", parity_error, 0);
    chk("par_cnt2", parity_err_cnt, 2);

    // Width masking
    do_load(8'hE3, 1'b1, 1'b1, 2'd0, 1'b1, 4'd5);
    chk("len5_data", data_out, 8'h03);
    chk("len5_perr", parity_error, 1);
    do_load(8'hE3, 1'b1, 1'b1, 2'd0, 1'b1, 4'd3);
    chk("len3_data", data_out, 8'hE3);
    chk("len3_perr", parity_error, 0);

    // Framing and stickiness
    do_clear();
    chk("clr_pcnt", parity_err_cnt, 0);
    do_load(8'h55, 1'b0, 1'b0, 2'd0, 1'b1, 4'd8);
    chk("fe_err", frame_error, 1);
    chk("fe_sticky", frame_sticky, 1);
    chk("fe_cnt", frame_err_cnt, 1);
    do_load(8'h55, 1'b0, 1'b1, 2'd0, 1'b1, 4'd8);
    chk("good_err", frame_error, 0);
    chk("good_sticky", frame_sticky, 1);
    chk("good_cnt", frame_err_cnt, 1);

    // Saturation: 20 back-to-back parity errors
    do_clear();
    pulses = 0;
    data_in = 8'h01; parity_bit = 1'b0; stop_bit = 1'b1; parity_type = 2'd0;
    parity_en = 1'b1; data_len = 4'd8; load = 1'b1;
    repeat (20) @(posedge clk);
    #1 load = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("sat_pulses", pulses, 20);
    chk("sat_cnt", parity_err_cnt, 15);
    chk("sat_sticky", parity_sticky, 1);

    // clear_stats alongside an error load
    clear_stats = 1'b1;
    do_load(8'h01, 1'b0, 1'b1, 2'd0, 1'b1, 4'd8);
    clear_stats = 1'b0;
    chk("clr_ld_cnt", parity_err_cnt, 0);
    chk("clr_ld_sticky", parity_sticky, 0);
    chk("clr_ld_valid", result_valid, 1);
    chk("clr_ld_perr", parity_error, 1);

    // Enable gating
    enable = 1'b0;
    do_load(8'h3C, 1'b1, 1'b0, 2'd0, 1'b1, 4'd8);
    chk("en_valid", result_valid, 0);
    chk("en_ferr", frame_error, 0);
    chk("en_data", data_out, 8'h01);
    chk("en_fcnt", frame_err_cnt, 0);
    enable = 1'b1;

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
